// File: rtl/hilo_unit.sv
// ---------------------------------------------------------------------------
// hilo_unit
//
// Controller and HI/LO register pair sitting between the execute stage and
// the multiply/divide unit. It accepts HI/LO-class instructions, launches
// multiply/divide operations with a one-cycle enable pulse, waits for the
// unit's in_operation flag to drop, captures the 64-bit result into HI/LO
// and stalls the pipeline on structural and read-after-write hazards.
//
// Ports:
//   clk             : rising-edge clock
//   rst_n           : synchronous active-low reset
//   op_valid        : instruction presented this cycle
//   op_code  [2:0]  : 0 multu, 1 mult, 2 divu, 3 div, 4 mthi, 5 mtlo,
//                     6 mfhi, 7 mflo
//   rs_val   [31:0] : first operand / mthi-mtlo source
//   rt_val   [31:0] : second operand
//   stall           : combinational, op not accepted this cycle
//   rd_valid        : registered 1-cycle pulse carrying mfhi/mflo data
//   rd_value [31:0] : registered mfhi/mflo data
//   hi, lo   [31:0] : architectural HI/LO registers
//   busy            : registered, md op outstanding
//   md_enable       : registered launch pulse to the md unit
//   md_value_1/2    : registered operands to the md unit
//   md_operation    : registered, op_code[1:0] of the launched op
//   md_out   [63:0] : md unit result {HI, LO}
//   md_in_operation : md unit busy flag
//
// Configuration macro:
//   HILO_DIV_ZERO_BYPASS_EN : when defined, div/divu with rt_val == 0 never
//                             launches the unit; HI <= rs_val and
//                             LO <= 32'hFFFF_FFFF in a single cycle.
// ---------------------------------------------------------------------------
module hilo_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        rd_valid,
    output logic [31:0] rd_value,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_enable,
    output logic [31:0] md_value_1,
    output logic [31:0] md_value_2,
    output logic [1:0]  md_operation,
    input  logic [63:0] md_out,
    input  logic        md_in_operation
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    state_t state;
    logic   accept;
    logic   div_zero;

    // Every op, including moves and reads, waits while an md op is in
    // flight; this covers all HI/LO hazards without forwarding. Checking
    // md_in_operation in IDLE keeps us off the unit if a reset abandoned it
    // mid-operation.
    assign stall  = op_valid & ((state != IDLE) | md_in_operation);
    assign accept = op_valid & ~stall;

`ifdef HILO_DIV_ZERO_BYPASS_EN
    // op_code[1] is set for divu/div; only consulted for codes 0-3.
    assign div_zero = op_code[1] & (rt_val == 32'd0);
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            hi           <= 32'd0;
            lo           <= 32'd0;
            rd_value     <= 32'd0;
            rd_valid     <= 1'b0;
            busy         <= 1'b0;
            md_enable    <= 1'b0;
            md_value_1   <= 32'd0;
            md_value_2   <= 32'd0;
            md_operation <= 2'd0;
        end else begin
            md_enable <= 1'b0;
            rd_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op_code)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                if (div_zero) begin
                                    hi <= rs_val;
                                    lo <= 32'hFFFF_FFFF;
                                end else begin
                                    md_value_1   <= rs_val;
                                    md_value_2   <= rt_val;
                                    md_operation <= op_code[1:0];
                                    md_enable    <= 1'b1;
                                    busy         <= 1'b1;
                                    state        <= LAUNCH;
                                end
                            end
                            3'd4: hi <= rs_val;
                            3'd5: lo <= rs_val;
                            // Reads see HI/LO as they stand before this edge.
                            3'd6: begin
                                rd_value <= hi;
                                rd_valid <= 1'b1;
                            end
                            default: begin
                                rd_value <= lo;
                                rd_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                // The unit samples md_enable at the end of this cycle and
                // only then raises in_operation, so WAIT must not look at
                // the flag before the next cycle.
                LAUNCH: state <= WAIT;
                // Completion is purely flag driven; no latency is assumed.
                WAIT: begin
                    if (!md_in_operation) begin
                        hi    <= md_out[63:32];
                        lo    <= md_out[31:0];
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_unit
//
// Directed testbench for hilo_unit. Contains a behavioural model of the
// multiply/divide unit (no reset, 1 edge busy for multiply, 34 edges busy
// for divide). Stimulus pushes expected read data and expected HI/LO
// captures into queues; a negedge monitor pops and compares whenever the
// DUT presents rd_valid or drops busy. Timing and hand-computed values are
// checked directly from the stimulus process.
// Honours HILO_DIV_ZERO_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_value;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_enable;
    logic [31:0] md_value_1;
    logic [31:0] md_value_2;
    logic [1:0]  md_operation;
    logic [63:0] md_out = 64'd0;
    logic        md_in_operation;

`ifdef HILO_DIV_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    hilo_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .op_valid        (op_valid),
        .op_code         (op_code),
        .rs_val          (rs_val),
        .rt_val          (rt_val),
        .stall           (stall),
        .rd_valid        (rd_valid),
        .rd_value        (rd_value),
        .hi              (hi),
        .lo              (lo),
        .busy            (busy),
        .md_enable       (md_enable),
        .md_value_1      (md_value_1),
        .md_value_2      (md_value_2),
        .md_operation    (md_operation),
        .md_out          (md_out),
        .md_in_operation (md_in_operation)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } rd_exp_t;

    rd_exp_t     rdq[$];
    logic [63:0] hiloq[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    function automatic logic [63:0] unitResult(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sp;
        logic [31:0]        q;
        logic [31:0]        r;
        case (op)
            2'd0: return {32'd0, a} * {32'd0, b};
            2'd1: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
        endcase
    endfunction

    // Multiply/divide unit model: busy from the edge after md_enable for
    // 1 edge (multiply) or 34 edges (divide), result valid when it drops.
    logic        unit_busy = 1'b0;
    int          unit_cnt  = 0;
    logic [63:0] unit_res  = 64'd0;

    always @(posedge clk) begin
        if (md_enable) begin
            unit_busy <= 1'b1;
            unit_cnt  <= md_operation[1] ? 34 : 1;
            unit_res  <= unitResult(md_operation, md_value_1, md_value_2);
        end else if (unit_busy) begin
            unit_cnt <= unit_cnt - 1;
            if (unit_cnt == 1) begin
                unit_busy <= 1'b0;
                md_out    <= unit_res;
            end
        end
    end

    assign md_in_operation = unit_busy;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic modelAccept(input logic [2:0] code, input logic [31:0] rs,
                               input logic [31:0] rt, input int c);
        logic [63:0] res;
        case (code)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                if (BYPASS && code[1] && rt == 32'd0) begin
                    model_hi = rs;
                    model_lo = 32'hFFFF_FFFF;
                end else begin
                    res      = unitResult(code[1:0], rs, rt);
                    model_hi = res[63:32];
                    model_lo = res[31:0];
                    hiloq.push_back(res);
                end
            end
            3'd4: model_hi = rs;
            3'd5: model_lo = rs;
            3'd6: rdq.push_back('{val: model_hi, cyc: c + 1});
            default: rdq.push_back('{val: model_lo, cyc: c + 1});
        endcase
    endtask

    // Called just after a rising edge; holds the op until accepted, returns
    // just after the accepting edge with op_valid dropped.
    task automatic applyStimulus(input logic [2:0] code, input logic [31:0] rs,
                                 input logic [31:0] rt, output int stalls,
                                 output int acc_cyc);
        bit done;
        done    = 1'b0;
        stalls  = 0;
        acc_cyc = -1;
        op_valid = 1'b1;
        op_code  = code;
        rs_val   = rs;
        rt_val   = rt;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!stall) begin
                done    = 1'b1;
                acc_cyc = cyc;
                modelAccept(code, rs, rt, cyc);
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            tests++;
            errors++;
            $display("[TB] FAIL accept_timeout: op %0d still stalled after 100 cycles", code);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic doReset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hiloq.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
    endtask

    // Monitor: read data, HI/LO captures and md_enable pulse width.
    rd_exp_t mon_e;
    logic    prev_busy = 1'b0;
    logic    prev_en   = 1'b0;
    int      en_cyc    = -1;

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (rdq.size() == 0) begin
                tests++;
                errors++;
                $display("[TB] FAIL rd_unexpected: got rd_value %0h, expected no read", rd_value);
            end else begin
                mon_e = rdq.pop_front();
                checkOutput("rd_value", rd_value, mon_e.val);
                checkOutput("rd_cycle", cyc, mon_e.cyc);
            end
        end
        if (rst_n && prev_busy && busy === 1'b0) begin
            if (hiloq.size() == 0) begin
                tests++;
                errors++;
                $display("[TB] FAIL hilo_unexpected: got busy drop with %0h, expected none", {hi, lo});
            end else begin
                checkOutput("hilo_capture", {hi, lo}, hiloq.pop_front());
            end
        end
        if (md_enable === 1'b1) begin
            checkOutput("md_enable_width", prev_en, 1'b0);
            en_cyc = cyc;
        end
        prev_busy = rst_n & (busy === 1'b1);
        prev_en   = (md_enable === 1'b1);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int s, a, a2;

    initial begin
        op_valid = 1'b0;
        op_code  = 3'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        doReset(2);

        // Reset values.
        @(negedge clk);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_md_enable", md_enable, 1'b0);
        checkOutput("reset_rd_valid", rd_valid, 1'b0);
        checkOutput("reset_rd_value", rd_value, 32'd0);
        checkOutput("reset_md_values", {md_value_1, md_value_2}, 64'd0);
        checkOutput("reset_md_operation", md_operation, 2'd0);
        checkOutput("reset_stall", stall, 1'b0);
        nextCycle();

        // mult -2 * 3, then mflo held during the stall.
        applyStimulus(3'd1, 32'hFFFF_FFFE, 32'd3, s, a);
        applyStimulus(3'd7, 32'd0, 32'd0, s, a2);
        checkOutput("mult_enable_cycle", en_cyc, a + 1);
        checkOutput("mult_stall_cycles", s, 3);
        checkOutput("mult_accept_cycle", a2, a + 4);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFFA);
        checkOutput("mult_operands", {md_value_1, md_value_2}, {32'hFFFF_FFFE, 32'd3});
        checkOutput("mult_operation", md_operation, 2'd1);

        // divu 100 / 7, mflo held until the capture is visible.
        applyStimulus(3'd2, 32'd100, 32'd7, s, a);
        applyStimulus(3'd7, 32'd0, 32'd0, s, a2);
        checkOutput("divu_stall_cycles", s, 36);
        checkOutput("divu_accept_cycle", a2, a + 37);
        checkOutput("divu_hi", hi, 32'd2);
        checkOutput("divu_lo", lo, 32'd14);

        // mthi then mfhi next cycle; mtlo then back-to-back reads.
        applyStimulus(3'd4, 32'h1234_5678, 32'd0, s, a);
        applyStimulus(3'd6, 32'd0, 32'd0, s, a2);
        checkOutput("mthi_mfhi_stall", s, 0);
        checkOutput("mthi_hi", hi, 32'h1234_5678);
        applyStimulus(3'd5, 32'hCAFE_F00D, 32'd0, s, a);
        applyStimulus(3'd7, 32'd0, 32'd0, s, a);
        applyStimulus(3'd6, 32'd0, 32'd0, s, a2);
        checkOutput("b2b_read_cycles", a2, a + 1);

        // multu, reset lands in cycle 2: result dropped.
        applyStimulus(3'd0, 32'd5, 32'd6, s, a);
        nextCycle();
        doReset(1);
        @(negedge clk);
        checkOutput("midreset_hi", hi, 32'd0);
        checkOutput("midreset_lo", lo, 32'd0);
        checkOutput("midreset_busy", busy, 1'b0);
        nextCycle();
        applyStimulus(3'd6, 32'd0, 32'd0, s, a);
        checkOutput("midreset_mult_stall", s, 0);
        checkOutput("midreset_mult_lo", lo, 32'd0);

        // divu, reset in cycle 2: next op waits for the orphaned unit.
        applyStimulus(3'd2, 32'd100, 32'd7, s, a);
        nextCycle();
        doReset(1);
        applyStimulus(3'd7, 32'd0, 32'd0, s, a2);
        checkOutput("midreset_div_stall", s, 33);
        checkOutput("midreset_div_hilo", {hi, lo}, 64'd0);

        // div 7 / 0.
        applyStimulus(3'd3, 32'd7, 32'd0, s, a);
`ifdef HILO_DIV_ZERO_BYPASS_EN
        checkOutput("divzero_md_enable", md_enable, 1'b0);
        checkOutput("divzero_busy", busy, 1'b0);
        checkOutput("divzero_hi", hi, 32'd7);
        checkOutput("divzero_lo", lo, 32'hFFFF_FFFF);
`else
        checkOutput("divzero_md_enable", md_enable, 1'b1);
        checkOutput("divzero_busy", busy, 1'b1);
        applyStimulus(3'd6, 32'd0, 32'd0, s, a2);
        checkOutput("divzero_hilo", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
`endif

        // Back-to-back multu then mult; results land in order.
        applyStimulus(3'd0, 32'h0001_0000, 32'h0003_0000, s, a);
        applyStimulus(3'd1, 32'hFFFF_FFFB, 32'd7, s, a2);
        checkOutput("b2b_mult_stall", s, 3);
        applyStimulus(3'd6, 32'd0, 32'd0, s, a2);
        checkOutput("b2b_mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("b2b_mult_lo", lo, 32'hFFFF_FFDD);

        // Signed divide -100 / 7.
        applyStimulus(3'd3, 32'hFFFF_FF9C, 32'd7, s, a);
        applyStimulus(3'd7, 32'd0, 32'd0, s, a2);
        checkOutput("div_signed_hilo", {hi, lo}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

        repeat (3) nextCycle();
        checkOutput("rd_queue_drained", rdq.size(), 0);
        checkOutput("hilo_queue_drained", hiloq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
